multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/multicycle_sequencer.sv | 145 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I control definitions: base opcodes and the multi-cycle sequencer state encoding.
package cpu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Encodings are visible on the debug port, so they are pinned explicitly.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd7
    } seq_state_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_JAL: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_S);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the cycle on which the stall limit is reached.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    output logic limit_hit
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [CW-1:0] count;

    // The MEM_TIMEOUT-th consecutive stalled cycle is the last one tolerated.
    assign limit_hit = count_en && (count == CW'(MEM_TIMEOUT - 1));

    // Any non-stalled cycle ends a wait sequence; every state change out of a
    // memory phase is either a ready cycle or the limit itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!count_en || limit_hit) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core: phase sequencing, strobe decode, trap and retire count.
//
// state      | meaning
// FETCH      | read instruction at PC, load IR on mem_ready
// DECODE     | check opcode legality
// EXECUTE    | ALU cycle; branches resolve and retire here
// MEMORY     | load/store data access, held until mem_ready
// WRITEBACK  | register-file write and PC update, retire
// TRAP       | halted until reset
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_target_sel,
    output logic             rf_write,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    seq_state_t cur_state;
    logic       wait_cycle;
    logic       wait_limit;

    assign wait_cycle = mem_req && !mem_ready;
    assign state      = cur_state;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_en  (wait_cycle),
        .limit_hit (wait_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state     <= ST_FETCH;
            retired_count <= '0;
        end else begin
            case (cur_state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        cur_state <= ST_DECODE;
                    end else if (wait_limit) begin
                        cur_state <= ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    cur_state <= is_legal_op(opcode) ? ST_EXECUTE : ST_TRAP;
                end
                ST_EXECUTE: begin
                    if (is_mem_op(opcode)) begin
                        cur_state <= ST_MEMORY;
                    end else if (opcode == OP_B) begin
                        cur_state     <= ST_FETCH;
                        retired_count <= retired_count + CNT_W'(1);
                    end else if (is_legal_op(opcode)) begin
                        cur_state <= ST_WRITEBACK;
                    end else begin
                        cur_state <= ST_TRAP;
                    end
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        if (opcode == OP_S) begin
                            cur_state     <= ST_FETCH;
                            retired_count <= retired_count + CNT_W'(1);
                        end else begin
                            cur_state <= ST_WRITEBACK;
                        end
                    end else if (wait_limit) begin
                        cur_state <= ST_TRAP;
                    end
                end
                ST_WRITEBACK: begin
                    cur_state     <= ST_FETCH;
                    retired_count <= retired_count + CNT_W'(1);
                end
                ST_TRAP: begin
                    cur_state <= ST_TRAP;
                end
                default: begin
                    cur_state <= ST_TRAP;
                end
            endcase
        end
    end

    // Strobes follow the registered state directly and are forced low while reset is held.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_is_fetch  = 1'b0;
        ir_load       = 1'b0;
        pc_write      = 1'b0;
        pc_target_sel = 1'b0;
        rf_write      = 1'b0;
        trap          = 1'b0;
        if (rst_n) begin
            case (cur_state)
                ST_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_load      = mem_ready;
                end
                ST_EXECUTE: begin
                    if (opcode == OP_B) begin
                        pc_write      = 1'b1;
                        pc_target_sel = branch_taken;
                    end
                end
                ST_MEMORY: begin
                    mem_req  = 1'b1;
                    mem_we   = (opcode == OP_S);
                    pc_write = mem_ready && (opcode == OP_S);
                end
                ST_WRITEBACK: begin
                    rf_write      = 1'b1;
                    pc_write      = 1'b1;
                    pc_target_sel = (opcode == OP_JAL);
                end
                ST_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: each instruction plan pushes per-cycle stimulus and expected outputs, checked cycle by cycle.
module tb_multicycle_sequencer;
    import cpu_pkg::*;

    localparam int TMO = 15;

    typedef struct {
        logic [6:0]  op;
        logic        ready;
        logic        taken;
        logic [10:0] vec;
        logic [3:0]  cnt;
    } entry_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_is_fetch, ir_load, pc_write, pc_target_sel, rf_write, trap;
    logic [2:0] state;
    logic [3:0] retired_count;
    logic [10:0] dut_vec;

    entry_t     sb[$];
    logic [3:0] model_cnt;
    int         n_checks;
    int         n_errors;

    multicycle_sequencer #(
        .CNT_W       (4),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_is_fetch  (mem_is_fetch),
        .ir_load       (ir_load),
        .pc_write      (pc_write),
        .pc_target_sel (pc_target_sel),
        .rf_write      (rf_write),
        .trap          (trap),
        .state         (state),
        .retired_count (retired_count)
    );

    assign dut_vec = {state, mem_req, mem_we, mem_is_fetch, ir_load, pc_write, pc_target_sel, rf_write, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [2:0] st, input logic req, input logic we,
                                       input logic fe, input logic ir, input logic pcw,
                                       input logic sel, input logic rfw, input logic tr);
        return {st, req, we, fe, ir, pcw, sel, rfw, tr};
    endfunction

    function automatic logic tb_legal(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b0100011 ||
               op == 7'b1100011 || op == 7'b0110111 || op == 7'b1101111;
    endfunction

    task automatic push_e(input logic [6:0] op, input logic ready, input logic taken, input logic [10:0] vec);
        entry_t e;
        e.op    = op;
        e.ready = ready;
        e.taken = taken;
        e.vec   = vec;
        e.cnt   = model_cnt;
        sb.push_back(e);
    endtask

    task automatic push_trap(input logic [6:0] op, input int n);
        for (int i = 0; i < n; i++)
            push_e(op, 1'($urandom_range(0, 1)), 1'b0, mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    // fw/mw: stalled cycles before mem_ready in FETCH/MEMORY; TMO or more means timeout.
    task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input logic tk);
        logic st;
        st = (op == 7'b0100011);
        for (int i = 0; i < fw && i < TMO; i++)
            push_e(op, 1'b0, 1'b0, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        if (fw >= TMO) begin
            push_trap(op, 3);
            return;
        end
        push_e(op, 1'b1, 1'b0, mk(3'd0, 1, 0, 1, 1, 0, 0, 0, 0));
        push_e(op, 1'($urandom_range(0, 1)), 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!tb_legal(op)) begin
            push_trap(op, 3);
            return;
        end
        if (op == 7'b1100011) begin
            push_e(op, 1'($urandom_range(0, 1)), tk, mk(3'd2, 0, 0, 0, 0, 1, tk, 0, 0));
            model_cnt = model_cnt + 4'd1;
            return;
        end
        push_e(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        if (op == 7'b0000011 || st) begin
            for (int i = 0; i < mw && i < TMO; i++)
                push_e(op, 1'b0, 1'b0, mk(3'd3, 1, st, 0, 0, 0, 0, 0, 0));
            if (mw >= TMO) begin
                push_trap(op, 3);
                return;
            end
            push_e(op, 1'b1, 1'b0, mk(3'd3, 1, st, 0, 0, st, 0, 0, 0));
            if (st) begin
                model_cnt = model_cnt + 4'd1;
                return;
            end
        end
        push_e(op, 1'($urandom_range(0, 1)), 1'b0, mk(3'd4, 0, 0, 0, 0, 1, op == 7'b1101111, 1, 0));
        model_cnt = model_cnt + 4'd1;
    endtask

    // Entered and left at a falling edge.
    task automatic run_sb(input string tag);
        entry_t e;
        while (sb.size() > 0) begin
            e            = sb.pop_front();
            opcode       = e.op;
            mem_ready    = e.ready;
            branch_taken = e.taken;
            #1;
            check_val({tag, "_outs"}, 32'(dut_vec), 32'(e.vec));
            check_val({tag, "_count"}, 32'(retired_count), 32'(e.cnt));
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_val({tag, "_rst_outs"}, 32'(dut_vec), 32'(0));
        check_val({tag, "_rst_count"}, 32'(retired_count), 32'(0));
        model_cnt = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        model_cnt    = 4'd0;
        rst_n        = 1'b0;
        opcode       = 7'd0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        do_reset("init");

        gen_instr(OP_R, 0, 0, 1'b0);
        run_sb("add");
        gen_instr(OP_LOAD, 0, 3, 1'b0);
        run_sb("load_wait");
        gen_instr(OP_S, 0, 0, 1'b0);
        gen_instr(OP_B, 0, 0, 1'b1);
        run_sb("store_beq");
        gen_instr(OP_I, 2, 0, 1'b0);
        gen_instr(OP_LUI, 0, 0, 1'b0);
        gen_instr(OP_JAL, 1, 0, 1'b0);
        gen_instr(OP_B, 0, 0, 1'b0);
        gen_instr(OP_S, 0, 2, 1'b0);
        run_sb("mix");
        gen_instr(OP_R, TMO - 1, 0, 1'b0);
        run_sb("fetch_edge");
        gen_instr(OP_LOAD, 0, TMO - 1, 1'b0);
        run_sb("mem_edge");

        gen_instr(7'b0000000, 0, 0, 1'b0);
        run_sb("illegal");
        do_reset("illegal");
        gen_instr(OP_R, TMO, 0, 1'b0);
        run_sb("fetch_tmo");
        do_reset("fetch_tmo");
        gen_instr(OP_S, 0, TMO, 1'b0);
        run_sb("mem_tmo");
        do_reset("mem_tmo");

        gen_instr(OP_R, 0, 0, 1'b0);
        push_e(OP_S, 1'b1, 1'b0, mk(3'd0, 1, 0, 1, 1, 0, 0, 0, 0));
        push_e(OP_S, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        push_e(OP_S, 1'b0, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        push_e(OP_S, 1'b0, 1'b0, mk(3'd3, 1, 1, 0, 0, 0, 0, 0, 0));
        push_e(OP_S, 1'b0, 1'b0, mk(3'd3, 1, 1, 0, 0, 0, 0, 0, 0));
        run_sb("mid_store");
        do_reset("mid_store");

        for (int i = 0; i < 16; i++)
            gen_instr(OP_R, $urandom_range(0, 2), 0, 1'b0);
        run_sb("wrap");
        #1;
        check_val("wrap_final", 32'(retired_count), 32'(model_cnt));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
